// File: rtl/of_stage_pipe.sv
// Operand-fetch stage for the SimpleRISC pipeline: decodes read addresses, reads the
// register file with writeback bypass, builds immediate and branch target, and registers the result.
module of_stage_pipe #(
    parameter int XLEN      = 32,
    parameter int RA_REG    = 15,
    parameter bit BYPASS_EN = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_pc,
    input  logic [31:0]     in_instr,
    output logic [3:0]      rf_raddr_a,
    output logic [3:0]      rf_raddr_b,
    input  logic [XLEN-1:0] rf_rdata_a,
    input  logic [XLEN-1:0] rf_rdata_b,
    input  logic            wb_en,
    input  logic [3:0]      wb_addr,
    input  logic [XLEN-1:0] wb_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [31:0]     out_instr,
    output logic [XLEN-1:0] out_op_a,
    output logic [XLEN-1:0] out_op_b,
    output logic [XLEN-1:0] out_imm,
    output logic [XLEN-1:0] out_br_target,
    output logic            out_imm_err
);

    localparam logic [4:0] OP_ST   = 5'b01111;
    localparam logic [4:0] OP_RET  = 5'b10100;
    localparam logic [3:0] RA_ADDR = 4'(RA_REG);

    logic [4:0]  opcode;
    logic        imm_flag;
    logic [3:0]  rd;
    logic [3:0]  rs1;
    logic [3:0]  rs2;
    logic [1:0]  imm_mod;
    logic [15:0] imm_val;
    logic [26:0] br_offset;

    assign opcode    = in_instr[31:27];
    assign imm_flag  = in_instr[26];
    assign rd        = in_instr[25:22];
    assign rs1       = in_instr[21:18];
    assign rs2       = in_instr[17:14];
    assign imm_mod   = in_instr[17:16];
    assign imm_val   = in_instr[15:0];
    assign br_offset = in_instr[26:0];

    assign rf_raddr_a = (opcode == OP_RET) ? RA_ADDR : rs1;
    assign rf_raddr_b = (opcode == OP_ST)  ? rd      : rs2;

    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;

    // Bypass covers r0 too; the register file owns any hardwired-zero behaviour.
    always_comb begin
        op_a = rf_rdata_a;
        op_b = rf_rdata_b;
        if (BYPASS_EN) begin
            if (wb_en && (wb_addr == rf_raddr_a)) op_a = wb_data;
            if (wb_en && (wb_addr == rf_raddr_b)) op_b = wb_data;
        end
    end

    logic [XLEN-1:0] imm;
    logic            imm_err;

    always_comb begin
        imm     = '0;
        imm_err = 1'b0;
        case (imm_mod)
            2'b00:   imm = XLEN'(imm_val);
            2'b01:   imm = XLEN'($signed(imm_val));
            2'b10:   imm = XLEN'({imm_val, 16'h0000});
            default: imm_err = imm_flag;
        endcase
    end

    logic [XLEN-1:0] br_offset_sext;
    logic [XLEN-1:0] br_target;

    assign br_offset_sext = XLEN'($signed(br_offset));
    assign br_target      = in_pc + (br_offset_sext << 2);

    logic            valid_q, valid_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [31:0]     instr_q, instr_d;
    logic [XLEN-1:0] op_a_q, op_a_d;
    logic [XLEN-1:0] op_b_q, op_b_d;
    logic [XLEN-1:0] imm_q, imm_d;
    logic [XLEN-1:0] br_target_q, br_target_d;
    logic            imm_err_q, imm_err_d;
    logic            load;

    assign in_ready = !valid_q || out_ready;
    assign load     = in_valid && in_ready && !flush;

    // Flush beats load beats drain; a held entry is never re-resolved against later writebacks.
    always_comb begin
        valid_d     = valid_q;
        pc_d        = pc_q;
        instr_d     = instr_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        imm_d       = imm_q;
        br_target_d = br_target_q;
        imm_err_d   = imm_err_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (load) begin
            valid_d     = 1'b1;
            pc_d        = in_pc;
            instr_d     = in_instr;
            op_a_d      = op_a;
            op_b_d      = op_b;
            imm_d       = imm;
            br_target_d = br_target;
            imm_err_d   = imm_err;
        end else if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q     <= 1'b0;
            pc_q        <= '0;
            instr_q     <= '0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            imm_q       <= '0;
            br_target_q <= '0;
            imm_err_q   <= 1'b0;
        end else begin
            valid_q     <= valid_d;
            pc_q        <= pc_d;
            instr_q     <= instr_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            imm_q       <= imm_d;
            br_target_q <= br_target_d;
            imm_err_q   <= imm_err_d;
        end
    end

    assign out_valid     = valid_q;
    assign out_pc        = pc_q;
    assign out_instr     = instr_q;
    assign out_op_a      = op_a_q;
    assign out_op_b      = op_b_q;
    assign out_imm       = imm_q;
    assign out_br_target = br_target_q;
    assign out_imm_err   = imm_err_q;

endmodule

// File: tb/tb_of_stage_pipe.sv
// Scoreboard bench for of_stage_pipe: directed vectors push hand-computed bundles,
// a negedge monitor pops and compares each accepted output.
module tb_of_stage_pipe;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [31:0] in_instr;
    logic [3:0]  rf_raddr_a;
    logic [3:0]  rf_raddr_b;
    logic [31:0] rf_rdata_a;
    logic [31:0] rf_rdata_b;
    logic        wb_en;
    logic [3:0]  wb_addr;
    logic [31:0] wb_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic [31:0] out_op_a;
    logic [31:0] out_op_b;
    logic [31:0] out_imm;
    logic [31:0] out_br_target;
    logic        out_imm_err;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] rdata_a;
        logic [31:0] rdata_b;
        logic        wb_en;
        logic [3:0]  wb_addr;
        logic [31:0] wb_data;
        logic [3:0]  raddr_a;
        logic [3:0]  raddr_b;
        logic [31:0] op_a;
        logic [31:0] op_b;
        logic [31:0] imm;
        logic [31:0] br;
        logic        err;
    } vec_t;

    vec_t exp_q[$];
    vec_t mon_e;
    vec_t vecs[10];
    vec_t bp[3];
    vec_t va;

    of_stage_pipe #(.XLEN(32), .RA_REG(15), .BYPASS_EN(1'b1)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_instr(in_instr),
        .rf_raddr_a(rf_raddr_a), .rf_raddr_b(rf_raddr_b),
        .rf_rdata_a(rf_rdata_a), .rf_rdata_b(rf_rdata_b),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr),
        .out_op_a(out_op_a), .out_op_b(out_op_b), .out_imm(out_imm),
        .out_br_target(out_br_target), .out_imm_err(out_imm_err)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Offers one instruction, waits (bounded) for acceptance, checks read addresses and queues the bundle.
    task automatic apply_stimulus(input vec_t v);
        int n = 0;
        in_valid   = 1'b1;
        in_pc      = v.pc;
        in_instr   = v.instr;
        rf_rdata_a = v.rdata_a;
        rf_rdata_b = v.rdata_b;
        wb_en      = v.wb_en;
        wb_addr    = v.wb_addr;
        wb_data    = v.wb_data;
        @(negedge clk);
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            check_output("accept_timeout", 32'(in_ready), 32'd1);
        end else begin
            check_output("raddr_a", 32'(rf_raddr_a), 32'(v.raddr_a));
            check_output("raddr_b", 32'(rf_raddr_b), 32'(v.raddr_b));
            exp_q.push_back(v);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        wb_en    = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        out_ready = 1'b1;
        @(negedge clk);
        while ((out_valid || exp_q.size() != 0) && n < 30) begin
            @(negedge clk);
            n++;
        end
        check_output("drain_done", 32'(exp_q.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_output: got pc %h instr %h expected none", out_pc, out_instr);
            end else begin
                mon_e = exp_q.pop_front();
                check_output("out_pc", out_pc, mon_e.pc);
                check_output("out_instr", out_instr, mon_e.instr);
                check_output("out_op_a", out_op_a, mon_e.op_a);
                check_output("out_op_b", out_op_b, mon_e.op_b);
                check_output("out_imm", out_imm, mon_e.imm);
                check_output("out_br_target", out_br_target, mon_e.br);
                check_output("out_imm_err", 32'(out_imm_err), 32'(mon_e.err));
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic vec_t mk(input logic [31:0] pc, input logic [31:0] instr,
                                input logic [31:0] ra, input logic [31:0] rb,
                                input logic we, input logic [3:0] wa, input logic [31:0] wd,
                                input logic [3:0] xa, input logic [3:0] xb,
                                input logic [31:0] oa, input logic [31:0] ob,
                                input logic [31:0] im, input logic [31:0] br, input logic er);
        vec_t v;
        v.pc = pc; v.instr = instr; v.rdata_a = ra; v.rdata_b = rb;
        v.wb_en = we; v.wb_addr = wa; v.wb_data = wd;
        v.raddr_a = xa; v.raddr_b = xb; v.op_a = oa; v.op_b = ob;
        v.imm = im; v.br = br; v.err = er;
        return v;
    endfunction

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_pc = '0; in_instr = '0;
        rf_rdata_a = '0; rf_rdata_b = '0; wb_en = 1'b0; wb_addr = '0; wb_data = '0;
        out_ready = 1'b0;

        // add r3,r1,r2; imm modifiers 00/01/10/11 on v=0x8001; branches; st; ret with bypass; port-B bypass
        vecs[0] = mk(32'h40,  32'h00C48000, 32'h5,  32'h7,  1'b0, 4'd0,  32'h0,    4'd1,  4'd2,  32'h5,    32'h7,    32'h00008000, 32'h03120040, 1'b0);
        vecs[1] = mk(32'h100, 32'h0C008001, 32'h11, 32'h22, 1'b0, 4'd0,  32'h0,    4'd0,  4'd2,  32'h11,   32'h22,   32'h00008001, 32'hF0020104, 1'b0);
        vecs[2] = mk(32'h100, 32'h0C018001, 32'h11, 32'h22, 1'b0, 4'd0,  32'h0,    4'd0,  4'd6,  32'h11,   32'h22,   32'hFFFF8001, 32'hF0060104, 1'b0);
        vecs[3] = mk(32'h100, 32'h0C028001, 32'h11, 32'h22, 1'b0, 4'd0,  32'h0,    4'd0,  4'd10, 32'h11,   32'h22,   32'h80010000, 32'hF00A0104, 1'b0);
        vecs[4] = mk(32'h100, 32'h0C038001, 32'h11, 32'h22, 1'b0, 4'd0,  32'h0,    4'd0,  4'd14, 32'h11,   32'h22,   32'h00000000, 32'hF00E0104, 1'b1);
        vecs[5] = mk(32'h100, 32'h87FFFFFF, 32'h33, 32'h44, 1'b0, 4'd0,  32'h0,    4'd15, 4'd15, 32'h33,   32'h44,   32'h00000000, 32'h000000FC, 1'b1);
        vecs[6] = mk(32'h100, 32'h80000004, 32'h33, 32'h44, 1'b0, 4'd0,  32'h0,    4'd0,  4'd0,  32'h33,   32'h44,   32'h00000004, 32'h00000110, 1'b0);
        vecs[7] = mk(32'h200, 32'h79880000, 32'h55, 32'h66, 1'b0, 4'd0,  32'h0,    4'd2,  4'd6,  32'h55,   32'h66,   32'h00000000, 32'h06200200, 1'b0);
        vecs[8] = mk(32'h300, 32'hA00C0000, 32'h0,  32'h77, 1'b1, 4'd15, 32'h1234, 4'd15, 4'd0,  32'h1234, 32'h77,   32'h00000000, 32'h00300300, 1'b0);
        vecs[9] = mk(32'h40,  32'h00C48000, 32'h5,  32'h7,  1'b1, 4'd2,  32'hBEEF, 4'd1,  4'd2,  32'h5,    32'hBEEF, 32'h00008000, 32'h03120040, 1'b0);

        bp[0] = mk(32'h40, 32'h00C48000, 32'h1, 32'h2, 1'b0, 4'd0, 32'h0, 4'd1, 4'd2, 32'h1, 32'h2, 32'h00008000, 32'h03120040, 1'b0);
        bp[1] = mk(32'h44, 32'h00C48000, 32'h3, 32'h4, 1'b0, 4'd0, 32'h0, 4'd1, 4'd2, 32'h3, 32'h4, 32'h00008000, 32'h03120044, 1'b0);
        bp[2] = mk(32'h48, 32'h00C48000, 32'h5, 32'h6, 1'b0, 4'd0, 32'h0, 4'd1, 4'd2, 32'h5, 32'h6, 32'h00008000, 32'h03120048, 1'b0);

        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check_output("reset_valid", 32'(out_valid), 32'd0);
        check_output("reset_in_ready", 32'(in_ready), 32'd1);
        check_output("reset_pc", out_pc, 32'h0);
        check_output("reset_op_a", out_op_a, 32'h0);
        check_output("reset_br", out_br_target, 32'h0);
        check_output("reset_imm_err", 32'(out_imm_err), 32'd0);
        @(posedge clk);
        #1;

        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) apply_stimulus(vecs[i]);
        wait_idle();

        out_ready = 1'b0;
        fork
            begin
                for (int i = 0; i < 3; i++) apply_stimulus(bp[i]);
            end
            begin
                @(negedge clk);
                @(negedge clk);
                check_output("bp_valid", 32'(out_valid), 32'd1);
                check_output("bp_in_ready", 32'(in_ready), 32'd0);
                repeat (2) @(negedge clk);
                check_output("bp_held_pc", out_pc, 32'h40);
                check_output("bp_held_op_a", out_op_a, 32'h1);
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        wait_idle();

        // Flush while full and stalled: held entry killed, offered entry dropped
        out_ready = 1'b0;
        va = mk(32'h400, 32'h00C48000, 32'h9, 32'h9, 1'b0, 4'd0, 32'h0, 4'd1, 4'd2, 32'h9, 32'h9, 32'h00008000, 32'h03120400, 1'b0);
        apply_stimulus(va);
        flush = 1'b1; in_valid = 1'b1; in_pc = 32'h500; in_instr = 32'h0C008001;
        @(negedge clk);
        check_output("flush_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        flush = 1'b0; in_valid = 1'b0;
        void'(exp_q.pop_back());
        @(negedge clk);
        check_output("flush_valid", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;

        // Flush on an empty stage with out_ready=1 still drops the offered instruction
        out_ready = 1'b1;
        flush = 1'b1; in_valid = 1'b1; in_pc = 32'h600;
        @(negedge clk);
        check_output("flush_empty_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        flush = 1'b0; in_valid = 1'b0;
        repeat (2) @(negedge clk);
        check_output("flush_empty_valid", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;

        // Reset while holding an instruction discards it
        out_ready = 1'b0;
        va = mk(32'h700, 32'h0C018001, 32'hAA, 32'hBB, 1'b0, 4'd0, 32'h0, 4'd0, 4'd6, 32'hAA, 32'hBB, 32'hFFFF8001, 32'hF0060704, 1'b0);
        apply_stimulus(va);
        reset = 1'b1; in_valid = 1'b1; in_pc = 32'h800;
        @(posedge clk);
        #1;
        reset = 1'b0; in_valid = 1'b0;
        void'(exp_q.pop_back());
        @(negedge clk);
        check_output("rst_mid_valid", 32'(out_valid), 32'd0);
        check_output("rst_mid_pc", out_pc, 32'h0);
        check_output("rst_mid_instr", out_instr, 32'h0);
        check_output("rst_mid_imm", out_imm, 32'h0);
        check_output("rst_mid_op_b", out_op_b, 32'h0);
        check_output("rst_mid_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        wait_idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
